// File: rtl/bank_sequencer.sv
// Bank sequencer: holds the execution and indirect bank registers and tracks
// (zp),Y opcodes so the indirect bank is driven on ba during the T4/T5 cycles.
module bank_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        sync,
   input  logic        rw,
   input  logic        rdy,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   output logic [3:0]  ba,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        ind_cycle
);

   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      T3,
      IND
   } state_t;

   localparam logic [7:0] OP_STA_IND_Y = 8'h91;
   localparam logic [7:0] OP_LDA_IND_Y = 8'hB1;

   state_t     state_q, state_d;
   logic [3:0] exec_bank_q, exec_bank_d;
   logic [3:0] ind_bank_q, ind_bank_d;

   logic cycle_done;
   logic sel_exec;
   logic sel_ind;
   logic is_ind_op;

   // Bus cycle completion and register address decode
   always_comb begin
      cycle_done = rdy | ~rw;
      sel_exec   = (addr == 16'h0000);
      sel_ind    = (addr == 16'h0001);
      is_ind_op  = (data_in == OP_STA_IND_Y) | (data_in == OP_LDA_IND_Y);
   end

   // Bank register writes, decoded on address alone
   always_comb begin
      exec_bank_d = exec_bank_q;
      ind_bank_d  = ind_bank_q;
      if (cycle_done && !rw) begin
         if (sel_exec) exec_bank_d = data_in[3:0];
         if (sel_ind)  ind_bank_d  = data_in[3:0];
      end
   end

   // Opcode sequencer: count T1..T3 after a (zp),Y fetch, then sit in IND
   always_comb begin
      state_d = state_q;
      if (cycle_done) begin
         if (sync) begin
            state_d = is_ind_op ? T1 : IDLE;
         end else begin
            case (state_q)
               IDLE:    state_d = IDLE;
               T1:      state_d = T2;
               T2:      state_d = T3;
               T3:      state_d = IND;
               IND:     state_d = IND;
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // State and bank registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         exec_bank_q <= 4'hF;
         ind_bank_q  <= 4'hF;
      end else begin
         state_q     <= state_d;
         exec_bank_q <= exec_bank_d;
         ind_bank_q  <= ind_bank_d;
      end
   end

   // Bank output; the sync cycle leaving IND already shows exec_bank
   always_comb begin
      ind_cycle = (state_q == IND) & ~sync;
      ba        = ind_cycle ? ind_bank_q : exec_bank_q;
   end

   // Register read-back
   always_comb begin
      data_oe  = rw & (sel_exec | sel_ind);
      data_out = 8'h00;
      if (data_oe) begin
         data_out = sel_exec ? {4'h0, exec_bank_q} : {4'h0, ind_bank_q};
      end
   end

endmodule

// File: tb/tb_bank_sequencer.sv
// Bench for bank_sequencer: directed scenarios plus randomized bus traffic
// compared against a cycle-counting model of the (zp),Y bank switch.
module tb_bank_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        sync;
   logic        rw;
   logic        rdy;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic [3:0]  ba;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        ind_cycle;

   int total = 0;
   int bad   = 0;

   // Model: bank values plus number of completed cycles since a (zp),Y fetch
   // (-1 = no indirect opcode in progress; 3 or more = indirect operand cycles).
   logic [3:0] m_exec;
   logic [3:0] m_ind;
   int         m_phase;

   bank_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .sync      (sync),
      .rw        (rw),
      .rdy       (rdy),
      .addr      (addr),
      .data_in   (data_in),
      .ba        (ba),
      .data_out  (data_out),
      .data_oe   (data_oe),
      .ind_cycle (ind_cycle)
   );

   always #5 clk = ~clk;

   function automatic logic exp_ind();
      return (m_phase >= 3) && !sync;
   endfunction

   function automatic logic [3:0] exp_ba();
      return exp_ind() ? m_ind : m_exec;
   endfunction

   function automatic logic exp_oe();
      return rw && (addr == 16'h0000 || addr == 16'h0001);
   endfunction

   function automatic logic [7:0] exp_dout();
      if (!exp_oe()) return 8'h00;
      return (addr == 16'h0000) ? {4'h0, m_exec} : {4'h0, m_ind};
   endfunction

   task automatic model_reset();
      m_exec  = 4'hF;
      m_ind   = 4'hF;
      m_phase = -1;
   endtask

   task automatic drive(input logic s, input logic r, input logic y,
                        input logic [15:0] a, input logic [7:0] d);
      sync = s; rw = r; rdy = y; addr = a; data_in = d;
      #2;
   endtask

   // End the current bus cycle and advance the model
   task automatic tick();
      @(posedge clk);
      if (rdy || !rw) begin
         if (!rw && addr == 16'h0000) m_exec = data_in[3:0];
         if (!rw && addr == 16'h0001) m_ind  = data_in[3:0];
         if (sync)
            m_phase = (data_in == 8'h91 || data_in == 8'hB1) ? 0 : -1;
         else if (m_phase >= 0 && m_phase < 3)
            m_phase = m_phase + 1;
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b1, 1'b1, 16'h8000, 8'h00);
      total++; if (ba !== 4'hF) begin bad++; $display("FAIL rst_ba got=%0h want=f", ba); end
      total++; if (ind_cycle !== 1'b0) begin bad++; $display("FAIL rst_ind got=%0b want=0", ind_cycle); end
      total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%0b want=0", data_oe); end
      // Read-back stays combinational while reset is held
      drive(1'b0, 1'b1, 1'b1, 16'h0001, 8'h00);
      total++; if (data_oe !== 1'b1) begin bad++; $display("FAIL rst_rd_oe got=%0b want=1", data_oe); end
      total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL rst_rd_dout got=%0h want=0f", data_out); end
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 16'h8000, 8'h00);
      total++; if (ba !== 4'hF) begin bad++; $display("FAIL idle_ba got=%0h want=f", ba); end
      total++; if (ind_cycle !== 1'b0) begin bad++; $display("FAIL idle_ind got=%0b want=0", ind_cycle); end
      total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL idle_oe got=%0b want=0", data_oe); end
      tick();
   endtask

   task automatic test_write_read();
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 8'h03);
      total++; if (ba !== 4'hF) begin bad++; $display("FAIL wr_same_cycle_ba got=%0h want=f", ba); end
      tick();
      drive(1'b0, 1'b1, 1'b1, 16'h0000, 8'h55);
      total++; if (ba !== 4'h3) begin bad++; $display("FAIL wr_next_ba got=%0h want=3", ba); end
      total++; if (data_oe !== 1'b1) begin bad++; $display("FAIL rd_oe got=%0b want=1", data_oe); end
      total++; if (data_out !== 8'h03) begin bad++; $display("FAIL rd_dout got=%0h want=03", data_out); end
      tick();
   endtask

   task automatic set_banks(input logic [3:0] e, input logic [3:0] i);
      drive(1'b0, 1'b0, 1'b1, 16'h0000, {4'hA, e}); tick();
      drive(1'b0, 1'b0, 1'b1, 16'h0001, {4'h5, i}); tick();
   endtask

   task automatic test_lda_no_cross();
      set_banks(4'h1, 4'h2);
      drive(1'b1, 1'b1, 1'b1, 16'h0400, 8'hB1);
      total++; if (ba !== 4'h1) begin bad++; $display("FAIL lda_t0_ba got=%0h want=1", ba); end
      tick();
      for (int c = 1; c <= 3; c++) begin
         drive(1'b0, 1'b1, 1'b1, 16'h0401 + 16'(c), 8'h40);
         total++; if (ba !== 4'h1) begin bad++; $display("FAIL lda_t%0d_ba got=%0h want=1", c, ba); end
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, 16'h3000, 8'h77);
      total++; if (ba !== 4'h2) begin bad++; $display("FAIL lda_t4_ba got=%0h want=2", ba); end
      total++; if (ind_cycle !== 1'b1) begin bad++; $display("FAIL lda_t4_ind got=%0b want=1", ind_cycle); end
      tick();
      drive(1'b1, 1'b1, 1'b1, 16'h0402, 8'hEA);
      total++; if (ba !== 4'h1) begin bad++; $display("FAIL lda_next_sync_ba got=%0h want=1", ba); end
      total++; if (ind_cycle !== 1'b0) begin bad++; $display("FAIL lda_next_sync_ind got=%0b want=0", ind_cycle); end
      tick();
   endtask

   task automatic test_sta_stall();
      set_banks(4'h1, 4'h2);
      drive(1'b1, 1'b1, 1'b1, 16'h0500, 8'h91); tick();
      for (int c = 1; c <= 3; c++) begin
         drive(1'b0, 1'b1, 1'b1, 16'h0500 + 16'(c), 8'h20); tick();
      end
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 1'b1, 1'b0, 16'h30FF, 8'h00);
         total++; if (ba !== 4'h2) begin bad++; $display("FAIL sta_stall%0d_ba got=%0h want=2", c, ba); end
         total++; if (ind_cycle !== 1'b1) begin bad++; $display("FAIL sta_stall%0d_ind got=%0b want=1", c, ind_cycle); end
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, 16'h30FF, 8'h00);
      total++; if (ba !== 4'h2) begin bad++; $display("FAIL sta_t4_ba got=%0h want=2", ba); end
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h3100, 8'h9C);
      total++; if (ba !== 4'h2) begin bad++; $display("FAIL sta_t5_ba got=%0h want=2", ba); end
      tick();
      drive(1'b1, 1'b1, 1'b1, 16'h0502, 8'hEA);
      total++; if (ba !== 4'h1) begin bad++; $display("FAIL sta_next_ba got=%0h want=1", ba); end
      tick();
   endtask

   task automatic test_abort_sync();
      set_banks(4'h1, 4'h2);
      drive(1'b1, 1'b1, 1'b1, 16'h0600, 8'hB1); tick();
      drive(1'b0, 1'b1, 1'b1, 16'h0601, 8'h20); tick();
      drive(1'b0, 1'b1, 1'b1, 16'h0020, 8'h00); tick();
      drive(1'b1, 1'b1, 1'b1, 16'h0602, 8'hEA);
      total++; if (ba !== 4'h1) begin bad++; $display("FAIL abort_sync_ba got=%0h want=1", ba); end
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 1'b1, 1'b1, 16'h0603, 8'h00);
         total++; if (ba !== 4'h1 || ind_cycle !== 1'b0)
            begin bad++; $display("FAIL abort_idle%0d ba=%0h ind=%0b want ba=1 ind=0", c, ba, ind_cycle); end
         tick();
      end
   endtask

   task automatic test_reset_in_ind();
      set_banks(4'h1, 4'h5);
      drive(1'b1, 1'b1, 1'b1, 16'h0700, 8'h91); tick();
      for (int c = 1; c <= 3; c++) begin
         drive(1'b0, 1'b1, 1'b1, 16'h0700 + 16'(c), 8'h20); tick();
      end
      drive(1'b0, 1'b1, 1'b0, 16'h4000, 8'h00);
      total++; if (ba !== 4'h5) begin bad++; $display("FAIL rind_pre_ba got=%0h want=5", ba); end
      reset = 1'b1;
      #1;
      model_reset();
      total++; if (ba !== 4'hF) begin bad++; $display("FAIL rind_async_ba got=%0h want=f", ba); end
      total++; if (ind_cycle !== 1'b0) begin bad++; $display("FAIL rind_async_ind got=%0b want=0", ind_cycle); end
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 16'h0001, 8'h00);
      total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL rind_readback got=%0h want=0f", data_out); end
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 1'b1, 1'b1, 16'h4001, 8'h00);
         total++; if (ba !== 4'hF || ind_cycle !== 1'b0)
            begin bad++; $display("FAIL rind_after%0d ba=%0h ind=%0b want ba=f ind=0", c, ba, ind_cycle); end
         tick();
      end
   endtask

   task automatic test_random();
      logic        s, r, y;
      logic [15:0] a;
      logic [7:0]  d;
      for (int n = 0; n < 600; n++) begin
         s = ($urandom_range(0, 4) == 0);
         r = s ? 1'b1 : ($urandom_range(0, 3) != 0);
         y = ($urandom_range(0, 4) != 0);
         case ($urandom_range(0, 5))
            0:       a = 16'h0000;
            1:       a = 16'h0001;
            default: a = 16'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       d = 8'h91;
            1:       d = 8'hB1;
            default: d = 8'($urandom);
         endcase
         drive(s, r, y, a, d);
         total++; if (ba !== exp_ba()) begin bad++; $display("FAIL rnd%0d_ba got=%0h want=%0h", n, ba, exp_ba()); end
         total++; if (ind_cycle !== exp_ind()) begin bad++; $display("FAIL rnd%0d_ind got=%0b want=%0b", n, ind_cycle, exp_ind()); end
         total++; if (data_oe !== exp_oe()) begin bad++; $display("FAIL rnd%0d_oe got=%0b want=%0b", n, data_oe, exp_oe()); end
         total++; if (data_out !== exp_dout()) begin bad++; $display("FAIL rnd%0d_dout got=%0h want=%0h", n, data_out, exp_dout()); end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      model_reset();
      test_reset();
      test_write_read();
      test_lda_no_cross();
      test_sta_stall();
      test_abort_sync();
      test_reset_in_ind();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
